vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60Hz VGA raster timing from the 25 MHz pixel clock.
//  Sits directly upstream of every sprite/colour stage, e.g. the full-screen
//  endgame image renderer. It supplies DrawX, DrawY and blank to those stages.
//  It drives hs/vs to the VGA/HDMI encoder, delayed so sync lines up with the
//  colour that the renderer registers one cycle later.
// PARAMETERS
//  H_VISIBLE    640  visible pixels per line
//  H_FRONT      16   horizontal front porch (pixels)
//  H_SYNC       96   horizontal sync width (pixels)
//  H_BACK       48   horizontal back porch; H_TOTAL = sum of the four = 800
//  V_VISIBLE    480  visible lines per frame
//  V_FRONT      10   vertical front porch (lines)
//  V_SYNC       2    vertical sync width (lines)
//  V_BACK       33   vertical back porch; V_TOTAL = 525
//  SYNC_DELAY   1    cycles hs/vs lag DrawX/DrawY/blank (range 0..4)
// PORTS
//  vga_clk      in   1   pixel clock, all logic on posedge
//  reset        in   1   synchronous, active-high
//  DrawX        out  10  current pixel column = horizontal counter
//  DrawY        out  10  current line = vertical counter
//  blank        out  1   1 = visible pixel (display enable), 0 = blanking
//  hs           out  1   horizontal sync, active-low, delayed SYNC_DELAY
//  vs           out  1   vertical sync, active-low, delayed SYNC_DELAY
//  frame_start  out  1   one-cycle pulse while DrawX==0 && DrawY==0
//  line_end     out  1   one-cycle pulse while DrawX==H_TOTAL-1
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset values: DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0,
//    line_end=0. Sync delay taps are all set to 1 (inactive).
//  - After reset, frame_start and blank rise together on the first posedge with
//    reset low. At that edge DrawX=0, DrawY=0, and counting begins.
//  - Counters are hc and vc. hc increments every cycle. On hc==H_TOTAL-1, hc
//    wraps to 0 and vc increments. On vc==V_TOTAL-1 at the same time, vc also
//    wraps to 0. There are no other wrap points.
//  - DrawX/DrawY are the counter registers themselves (zero latency), 10 bits.
//  - blank, frame_start and line_end are registered. Each is computed from the
//    next-state counters, so it is valid in the same cycle as the DrawX/DrawY it
//    describes.
//  - blank = (hc < H_VISIBLE) && (vc < V_VISIBLE).
//  - The raw hsync is low when H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC,
//    i.e. 656..751.
//  - The raw vsync is low when V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC,
//    i.e. 490..491, for the whole of each such line.
//  - hs/vs = raw sync passed through a SYNC_DELAY-stage shift register.
//    SYNC_DELAY=0 means they are registered exactly like blank.
//  - Reset asserted mid-frame: on the next edge, all outputs return to their
//    reset values and the delay taps are flushed to 1. No partial sync pulse may
//    appear after reset.
//  - Reset held for several cycles: outputs stay static at the reset values.
// STRUCTURE
//  - Package vga_pkg holds:
//    - the default timing constants;
//    - H_TOTAL and V_TOTAL as localparams;
//    - a typedef coord_t = logic [9:0], reused by downstream renderers.
//  - Sub-module sync_delay (params WIDTH=2, DEPTH=SYNC_DELAY, RESET_VAL=1).
//    It is a synchronous-reset shift register that carries {hs_raw, vs_raw}.
// TESTING
//  - Reset 3 cycles, release. Required: cycle 0 has DrawX=0, DrawY=0, blank=1,
//    frame_start=1, hs=1, vs=1. Cycle 1 has DrawX=1, frame_start=0.
//  - Run 800 cycles. Required: line_end exactly once, at DrawX=799. Next cycle
//    DrawX=0, DrawY=1.
//  - Line 0, SYNC_DELAY=1. Required: hs falls one cycle after DrawX==656, stays
//    low exactly 96 cycles, and rises one cycle after DrawX==752.
//  - Full frame of 420000 cycles. Required:
//    - blank=1 on exactly 307200 cycles;
//    - vs low for exactly 1600 cycles (lines 490-491, shifted by delay);
//    - frame_start exactly once;
//    - after 524/799 the counters return to 0/0.
//  - Assert reset at DrawX=700, DrawY=490, i.e. inside hsync and vsync. Required:
//    next edge gives hs=1, vs=1, blank=0, DrawX=0, DrawY=0, with no stray low
//    pulse on hs or vs during the two cycles after release.
//  - SYNC_DELAY=0 and SYNC_DELAY=3 builds. Required: hs falling edge lags the
//    DrawX==656 cycle by 0 and 3 cycles respectively. Period stays 800.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60Hz timing constants and coordinate type.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned DEFAULT_SYNC_DELAY = 1;

  // Half-open window test [lo, hi) used for the sync pulses.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Synchronous-reset shift register that lags the raw sync pair; DEPTH=0 is a wire.
module sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned DEPTH     = DEFAULT_SYNC_DELAY,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // No extra lag requested: the input is already registered upstream.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, vga_clk, reset};
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] taps [DEPTH];

      // Shift one stage per cycle; reset flushes every tap to the inactive level.
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) taps[i] <= {WIDTH{RESET_VAL}};
        end else begin
          taps[0] <= d;
          for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
      end

      assign q = taps[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, display enable, frame/line pulses and
// active-low syncs lagged so they line up with the downstream registered colour.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS      = H_VISIBLE,
  parameter int unsigned H_FP       = H_FRONT,
  parameter int unsigned H_SW       = H_SYNC,
  parameter int unsigned H_BP       = H_BACK,
  parameter int unsigned V_VIS      = V_VISIBLE,
  parameter int unsigned V_FP       = V_FRONT,
  parameter int unsigned V_SW       = V_SYNC,
  parameter int unsigned V_BP       = V_BACK,
  parameter int unsigned SYNC_DELAY = DEFAULT_SYNC_DELAY
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       line_end
);

  localparam coord_t H_LAST  = coord_t'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam coord_t V_LAST  = coord_t'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam coord_t H_VIS_C = coord_t'(H_VIS);
  localparam coord_t V_VIS_C = coord_t'(V_VIS);
  localparam coord_t HS_LO   = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_HI   = coord_t'(H_VIS + H_FP + H_SW);
  localparam coord_t VS_LO   = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_HI   = coord_t'(V_VIS + V_FP + V_SW);

  coord_t     hc;
  coord_t     vc;
  coord_t     hc_nxt;
  coord_t     vc_nxt;
  logic       running;
  logic       hs_raw;
  logic       vs_raw;
  logic [1:0] sync_q;

  // Next counter values; the first edge after reset holds 0/0 so pixel 0 is shown.
  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    if (running) begin
      if (hc == H_LAST) begin
        hc_nxt = '0;
        vc_nxt = (vc == V_LAST) ? '0 : vc + coord_t'(1);
      end else begin
        hc_nxt = hc + coord_t'(1);
      end
    end
  end

  // Counters plus flags decoded from the next counters, so flags match DrawX/DrawY.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      running     <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
    end else begin
      running     <= 1'b1;
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      blank       <= (hc_nxt < H_VIS_C) && (vc_nxt < V_VIS_C);
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
      line_end    <= (hc_nxt == H_LAST);
      hs_raw      <= ~in_window(hc_nxt, HS_LO, HS_HI);
      vs_raw      <= ~in_window(vc_nxt, VS_LO, VS_HI);
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  // Extra lag on the syncs only.
  sync_delay #(
    .WIDTH    (2),
    .DEPTH    (SYNC_DELAY),
    .RESET_VAL(1'b1)
  ) u_sync_delay (
    .vga_clk(vga_clk),
    .reset  (reset),
    .d      ({hs_raw, vs_raw}),
    .q      (sync_q)
  );

  assign hs = sync_q[1];
  assign vs = sync_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (delays 0/1/3 at full timing, plus a
// shrunken raster for whole-frame checks) compared against a cycle-index model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       le;
  } obs_t;

  typedef struct packed {
    int hv; int hf; int hsw; int hb;
    int vv; int vf; int vsw; int vb;
    int d;
  } tim_t;

  typedef logic [4*$bits(obs_t)-1:0] all_t;

  localparam tim_t T0 = '{hv:640, hf:16, hsw:96, hb:48, vv:480, vf:10, vsw:2, vb:33, d:0};
  localparam tim_t T1 = '{hv:640, hf:16, hsw:96, hb:48, vv:480, vf:10, vsw:2, vb:33, d:1};
  localparam tim_t T3 = '{hv:640, hf:16, hsw:96, hb:48, vv:480, vf:10, vsw:2, vb:33, d:3};
  localparam tim_t TS = '{hv:16,  hf:4,  hsw:6,  hb:6,  vv:12,  vf:2,  vsw:2, vb:4,  d:1};

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  int   t       = -1;
  int   passed  = 0;
  int   total   = 0;

  always #20 vga_clk = ~vga_clk;

  // Cycle index since release: 0 on the first edge with reset low.
  always @(posedge vga_clk) t <= reset ? -1 : t + 1;

  logic [9:0] x0, y0, x1, y1, x3, y3, xs, ys;
  logic b0, h0, v0, f0, l0;
  logic b1, h1, v1, f1, l1;
  logic b3, h3, v3, f3, l3;
  logic bs, hs_s, vs_s, fs_s, ls;

  vga_timing_gen #(.SYNC_DELAY(0)) d0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(x0), .DrawY(y0), .blank(b0),
    .hs(h0), .vs(v0), .frame_start(f0), .line_end(l0));
  vga_timing_gen d1 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(x1), .DrawY(y1), .blank(b1),
    .hs(h1), .vs(v1), .frame_start(f1), .line_end(l1));
  vga_timing_gen #(.SYNC_DELAY(3)) d3 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(x3), .DrawY(y3), .blank(b3),
    .hs(h3), .vs(v3), .frame_start(f3), .line_end(l3));
  vga_timing_gen #(.H_VIS(16), .H_FP(4), .H_SW(6), .H_BP(6),
                   .V_VIS(12), .V_FP(2), .V_SW(2), .V_BP(4), .SYNC_DELAY(1)) ds (
    .vga_clk(vga_clk), .reset(reset), .DrawX(xs), .DrawY(ys), .blank(bs),
    .hs(hs_s), .vs(vs_s), .frame_start(fs_s), .line_end(ls));

  // Expected outputs at cycle tt (tt<0 means reset was sampled on the last edge).
  function automatic obs_t model(tim_t c, int tt);
    obs_t o;
    int ht, vt, px, ln, u;
    ht = c.hv + c.hf + c.hsw + c.hb;
    vt = c.vv + c.vf + c.vsw + c.vb;
    o = '{x:10'd0, y:10'd0, blank:1'b0, hs:1'b1, vs:1'b1, fs:1'b0, le:1'b0};
    if (tt < 0) return o;
    px = tt % ht;
    ln = (tt / ht) % vt;
    o.x     = 10'(px);
    o.y     = 10'(ln);
    o.blank = (px < c.hv) && (ln < c.vv);
    o.fs    = (px == 0) && (ln == 0);
    o.le    = (px == ht - 1);
    u = tt - c.d;
    if (u >= 0) begin
      o.hs = !(((u % ht) >= c.hv + c.hf) && ((u % ht) < c.hv + c.hf + c.hsw));
      o.vs = !((((u / ht) % vt) >= c.vv + c.vf) && (((u / ht) % vt) < c.vv + c.vf + c.vsw));
    end
    return o;
  endfunction

  function automatic all_t exp_all();
    return {model(T0, t), model(T1, t), model(T3, t), model(TS, t)};
  endfunction

  function automatic all_t obs_all();
    return {x0, y0, b0, h0, v0, f0, l0, x1, y1, b1, h1, v1, f1, l1,
            x3, y3, b3, h3, v3, f3, l3, xs, ys, bs, hs_s, vs_s, fs_s, ls};
  endfunction

  // Hold reset n edges, then release; the next negedge observes cycle 0.
  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) @(negedge vga_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge vga_clk);
      total++;
      if (obs_all() !== exp_all()) $display("FAIL reset_hold t=%0d got %h want %h", t, obs_all(), exp_all());
      else passed++;
    end
    reset = 1'b0;
    @(negedge vga_clk);
    total++;
    if ({x1, y1, b1, f1, h1, v1} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1})
      $display("FAIL cycle0 got x=%0d y=%0d b=%b fs=%b hs=%b vs=%b want 0 0 1 1 1 1", x1, y1, b1, f1, h1, v1);
    else passed++;
    total++;
    if (obs_all() !== exp_all()) $display("FAIL cycle0_all got %h want %h", obs_all(), exp_all());
    else passed++;
    @(negedge vga_clk);
    total++;
    if ({x1, f1} !== {10'd1, 1'b0}) $display("FAIL cycle1 got x=%0d fs=%b want x=1 fs=0", x1, f1);
    else passed++;
  endtask

  task automatic test_line();
    int le_cnt, le_x;
    int fall1 [3], fall2 [3], rise1 [3], low_cnt [3], nf [3];
    logic prev [3], cur [3];
    do_reset(2);
    le_cnt = 0; le_x = -1;
    for (int k = 0; k < 3; k++) begin
      fall1[k] = -1; fall2[k] = -1; rise1[k] = -1; low_cnt[k] = 0; nf[k] = 0; prev[k] = 1'b1;
    end
    for (int i = 0; i < 1600; i++) begin
      @(negedge vga_clk);
      total++;
      if (obs_all() !== exp_all()) $display("FAIL line_model t=%0d got %h want %h", t, obs_all(), exp_all());
      else passed++;
      if (i == 800) begin
        total++;
        if ({x1, y1} !== {10'd0, 10'd1}) $display("FAIL line_wrap got x=%0d y=%0d want 0 1", x1, y1);
        else passed++;
      end
      cur[0] = h0; cur[1] = h1; cur[2] = h3;
      if (i < 800 && l1) begin le_cnt++; le_x = int'(x1); end
      for (int k = 0; k < 3; k++) begin
        if (i < 800 && !cur[k]) low_cnt[k]++;
        if (prev[k] && !cur[k]) begin
          if (nf[k] == 0) fall1[k] = i; else if (nf[k] == 1) fall2[k] = i;
          nf[k]++;
        end
        if (!prev[k] && cur[k] && rise1[k] < 0) rise1[k] = i;
        prev[k] = cur[k];
      end
    end
    total++;
    if (le_cnt != 1 || le_x != 799) $display("FAIL line_end got count=%0d x=%0d want 1 at 799", le_cnt, le_x);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      int dl;
      dl = (k == 0) ? 0 : (k == 1) ? 1 : 3;
      total++;
      if (fall1[k] != 656 + dl) $display("FAIL hs_fall d=%0d got %0d want %0d", dl, fall1[k], 656 + dl);
      else passed++;
      total++;
      if (rise1[k] != 752 + dl) $display("FAIL hs_rise d=%0d got %0d want %0d", dl, rise1[k], 752 + dl);
      else passed++;
      total++;
      if (low_cnt[k] != 96) $display("FAIL hs_width d=%0d got %0d want 96", dl, low_cnt[k]);
      else passed++;
      total++;
      if (fall2[k] - fall1[k] != 800) $display("FAIL hs_period d=%0d got %0d want 800", dl, fall2[k] - fall1[k]);
      else passed++;
    end
  endtask

  task automatic test_full_frame();
    int blank_cnt, vs_low, fs_cnt;
    do_reset(2);
    blank_cnt = 0; vs_low = 0; fs_cnt = 0;
    for (int i = 0; i < 640; i++) begin
      @(negedge vga_clk);
      total++;
      if (obs_all() !== exp_all()) $display("FAIL frame_model t=%0d got %h want %h", t, obs_all(), exp_all());
      else passed++;
      if (bs) blank_cnt++;
      if (!vs_s) vs_low++;
      if (fs_s) fs_cnt++;
    end
    total++;
    if (blank_cnt != 16 * 12) $display("FAIL frame_blank got %0d want %0d", blank_cnt, 16 * 12);
    else passed++;
    total++;
    if (vs_low != 2 * 32) $display("FAIL frame_vs_low got %0d want %0d", vs_low, 2 * 32);
    else passed++;
    total++;
    if (fs_cnt != 1) $display("FAIL frame_start_count got %0d want 1", fs_cnt);
    else passed++;
    @(negedge vga_clk);
    total++;
    if ({xs, ys, fs_s} !== {10'd0, 10'd0, 1'b1}) $display("FAIL frame_wrap got x=%0d y=%0d fs=%b want 0 0 1", xs, ys, fs_s);
    else passed++;
  endtask

  // Reset landing inside active sync: outputs snap back with no stray sync pulse.
  task automatic test_reset_in_sync();
    for (int pass = 0; pass < 2; pass++) begin
      int  n;
      logic hit;
      do_reset(2);
      n = 0; hit = 1'b0;
      while (!hit && n < 2000) begin
        @(negedge vga_clk);
        n++;
        hit = (pass == 0) ? (x1 == 10'd700) : (xs == 10'd22 && ys == 10'd14);
      end
      total++;
      if (!hit) $display("FAIL sync_reset_wait pass=%0d got timeout want target", pass);
      else passed++;
      total++;
      if ((pass == 0 ? h1 : (hs_s | vs_s)) !== 1'b0)
        $display("FAIL sync_reset_inside pass=%0d got h1=%b hs_s=%b vs_s=%b want low", pass, h1, hs_s, vs_s);
      else passed++;
      reset = 1'b1;
      @(negedge vga_clk);
      total++;
      if ({h1, v1, b1, x1, y1, hs_s, vs_s, bs, xs, ys} !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0})
        $display("FAIL sync_reset_values pass=%0d got hs=%b vs=%b b=%b x=%0d y=%0d hs_s=%b vs_s=%b", pass, h1, v1, b1, x1, y1, hs_s, vs_s);
      else passed++;
      reset = 1'b0;
      repeat (2) begin
        @(negedge vga_clk);
        total++;
        if ({h0, v0, h1, v1, h3, v3, hs_s, vs_s} !== 8'hFF)
          $display("FAIL sync_after_release pass=%0d t=%0d got %b want 11111111", pass, t, {h0, v0, h1, v1, h3, v3, hs_s, vs_s});
        else passed++;
        total++;
        if (obs_all() !== exp_all()) $display("FAIL sync_release_model t=%0d got %h want %h", t, obs_all(), exp_all());
        else passed++;
      end
    end
  endtask

  // Random run lengths interleaved with random-length resets.
  task automatic test_random_resets();
    for (int it = 0; it < 20; it++) begin
      int run_len, rst_len;
      run_len = int'($urandom_range(50, 3000));
      rst_len = int'($urandom_range(1, 4));
      reset = 1'b0;
      repeat (run_len) begin
        @(negedge vga_clk);
        total++;
        if (obs_all() !== exp_all()) $display("FAIL random_run it=%0d t=%0d got %h want %h", it, t, obs_all(), exp_all());
        else passed++;
      end
      reset = 1'b1;
      repeat (rst_len) begin
        @(negedge vga_clk);
        total++;
        if (obs_all() !== exp_all()) $display("FAIL random_reset it=%0d got %h want %h", it, obs_all(), exp_all());
        else passed++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line();
    test_full_frame();
    test_reset_in_sync();
    test_random_resets();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
